nvme_sq_arbiter: RTL and testbench

//   Shares the single NVMe command executor between NUM_SQ submission queues.

---
 rtl/nvme_sq_arbiter_if.sv | 33 +++
 rtl/nvme_sq_arbiter.sv | 171 +++++++++++++++++
 tb/tb_nvme_sq_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nvme_sq_arbiter_if.sv
// rtl/nvme_sq_arbiter_if.sv - SQ, executor and completion signal bundle for nvme_sq_arbiter
interface nvme_sq_arbiter_if #(
  parameter int NUM_SQ = 4,
  parameter int CMD_W  = 16
);
  localparam int QID_W = $clog2(NUM_SQ);

  logic [NUM_SQ-1:0]       sq_valid;
  logic [NUM_SQ*CMD_W-1:0] sq_cmd;
  logic [NUM_SQ-1:0]       sq_ready;
  logic                    cmd_valid;
  logic [CMD_W-1:0]        cmd_data;
  logic [QID_W-1:0]        cmd_qid;
  logic                    cmd_ready;
  logic                    cpl_valid;
  logic                    cpl_err;
  logic                    done_valid;
  logic [QID_W-1:0]        done_qid;
  logic [1:0]              done_status;
  logic                    busy;

  // Arbiter side
  modport master (
    input  sq_valid, sq_cmd, cmd_ready, cpl_valid, cpl_err,
    output sq_ready, cmd_valid, cmd_data, cmd_qid, done_valid, done_qid, done_status, busy
  );

  // SQ fetch / executor side
  modport slave (
    output sq_valid, sq_cmd, cmd_ready, cpl_valid, cpl_err,
    input  sq_ready, cmd_valid, cmd_data, cmd_qid, done_valid, done_qid, done_status, busy
  );
endinterface

// File: rtl/nvme_sq_arbiter.sv
// rtl/nvme_sq_arbiter.sv - round-robin/burst arbiter sharing one NVMe executor among NUM_SQ SQs
// Optional build macro NVME_SQ_URGENT_EN: queue 0 becomes strict priority outside the round-robin.
module nvme_sq_arbiter #(
  parameter int NUM_SQ      = 4,
  parameter int CMD_W       = 16,
  parameter int BURST       = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  nvme_sq_arbiter_if.master bus
);
  localparam int QID_W = $clog2(NUM_SQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYC);
  localparam int BC_W  = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CMD_W-1:0]  cmd_data_q, cmd_data_d;
  logic [QID_W-1:0]  cmd_qid_q, cmd_qid_d;
  logic [QID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              done_valid_q, done_valid_d;
  logic [QID_W-1:0]  done_qid_q, done_qid_d;
  logic [1:0]        done_status_q, done_status_d;

  logic [QID_W-1:0]  winner;
  logic              found;
  logic [QID_W:0]    srch_sum;
  logic [QID_W-1:0]  next_qid;
  logic [NUM_SQ-1:0] sq_ready_c;
  logic              leave;
  logic              timed_out;
  logic              q0_exempt_grant;
  logic              q0_exempt_done;

  // Winner = first valid queue at or after rr_ptr, wrapping; urgent build lets queue 0 jump ahead
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    srch_sum = '0;
    for (int k = 0; k < NUM_SQ; k++) begin
      srch_sum = {1'b0, rr_ptr_q} + (QID_W+1)'(k);
      if (srch_sum >= (QID_W+1)'(NUM_SQ)) begin
        srch_sum = srch_sum - (QID_W+1)'(NUM_SQ);
      end
      if (!found && bus.sq_valid[srch_sum[QID_W-1:0]]) begin
        found  = 1'b1;
        winner = srch_sum[QID_W-1:0];
      end
    end
`ifdef NVME_SQ_URGENT_EN
    if (bus.sq_valid[0]) begin
      winner = '0;
    end
`endif
  end

`ifdef NVME_SQ_URGENT_EN
  assign q0_exempt_grant = (winner == '0);
  assign q0_exempt_done  = (cmd_qid_q == '0);
`else
  assign q0_exempt_grant = 1'b0;
  assign q0_exempt_done  = 1'b0;
`endif

  assign next_qid = (cmd_qid_q == QID_W'(NUM_SQ - 1)) ? '0 : cmd_qid_q + 1'b1;

  // Next-state logic: grant in IDLE, hand off in ISSUE, wait for completion or timeout in WAIT
  always_comb begin
    state_d       = state_q;
    cmd_data_d    = cmd_data_q;
    cmd_qid_d     = cmd_qid_q;
    rr_ptr_d      = rr_ptr_q;
    burst_cnt_d   = burst_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    done_valid_d  = 1'b0;
    done_qid_d    = done_qid_q;
    done_status_d = done_status_q;
    sq_ready_c    = '0;
    leave         = 1'b0;
    timed_out     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|bus.sq_valid) begin
          sq_ready_c[winner] = 1'b1;
          cmd_data_d         = bus.sq_cmd[winner*CMD_W +: CMD_W];
          cmd_qid_d          = winner;
          state_d            = S_ISSUE;
          // A queue other than the favoured one starts a fresh burst
          if (!q0_exempt_grant && (winner != rr_ptr_q)) begin
            burst_cnt_d = '0;
          end
        end
      end
      S_ISSUE: begin
        if (bus.cmd_ready) begin
          state_d  = S_WAIT;
          wd_cnt_d = '0;
        end
      end
      S_WAIT: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        if (bus.cpl_valid) begin
          leave         = 1'b1;
          done_status_d = {1'b0, bus.cpl_err};
        end else if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
          leave         = 1'b1;
          timed_out     = 1'b1;
          done_status_d = 2'b10;
        end
        if (leave) begin
          done_valid_d = 1'b1;
          done_qid_d   = cmd_qid_q;
          state_d      = S_IDLE;
          if (!q0_exempt_done) begin
            if (!timed_out && (int'(burst_cnt_q) < BURST - 1)) begin
              burst_cnt_d = burst_cnt_q + 1'b1;
              rr_ptr_d    = cmd_qid_q;
            end else begin
              burst_cnt_d = '0;
              rr_ptr_d    = next_qid;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight command silently
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cmd_data_q    <= '0;
      cmd_qid_q     <= '0;
      rr_ptr_q      <= '0;
      burst_cnt_q   <= '0;
      wd_cnt_q      <= '0;
      done_valid_q  <= 1'b0;
      done_qid_q    <= '0;
      done_status_q <= 2'b00;
    end else begin
      state_q       <= state_d;
      cmd_data_q    <= cmd_data_d;
      cmd_qid_q     <= cmd_qid_d;
      rr_ptr_q      <= rr_ptr_d;
      burst_cnt_q   <= burst_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      done_valid_q  <= done_valid_d;
      done_qid_q    <= done_qid_d;
      done_status_q <= done_status_d;
    end
  end

  assign bus.sq_ready    = sq_ready_c;
  assign bus.cmd_valid   = (state_q == S_ISSUE);
  assign bus.cmd_data    = cmd_data_q;
  assign bus.cmd_qid     = cmd_qid_q;
  assign bus.done_valid  = done_valid_q;
  assign bus.done_qid    = done_qid_q;
  assign bus.done_status = done_status_q;
  assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_nvme_sq_arbiter.sv
// tb/tb_nvme_sq_arbiter.sv - scoreboard bench for nvme_sq_arbiter with a queue-level reference model
module tb_nvme_sq_arbiter;
  localparam int NUM_SQ = 4;
  localparam int CMD_W  = 16;
  localparam int BURST  = 2;
  localparam int TMO    = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  nvme_sq_arbiter_if #(.NUM_SQ(NUM_SQ), .CMD_W(CMD_W)) bus ();

  nvme_sq_arbiter #(
    .NUM_SQ(NUM_SQ), .CMD_W(CMD_W), .BURST(BURST), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { int qid; int cmd; } grant_t;
  typedef struct { int qid; int status; } done_t;

  grant_t exp_grant[$];
  done_t  exp_done[$];
  int     grant_log[$];
  int     checks = 0;
  int     failures = 0;
  int     m_rr = 0;
  int     m_burst = 0;
  int     cur_qid = -1;
  int     cur_cmd = 0;
  logic [CMD_W-1:0] cmds [NUM_SQ];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic abort(input string name);
    checks++;
    failures++;
    $display("FAIL %s wait bound expired", name);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench stopped");
  endtask

  // Reference model: the queue the round-robin rules pick for a given valid mask
  function automatic int model_pick(input logic [NUM_SQ-1:0] m);
    int mi;
    int idx;
    mi = int'(m);
`ifdef NVME_SQ_URGENT_EN
    if ((mi & 1) != 0) return 0;
`endif
    for (int k = 0; k < NUM_SQ; k++) begin
      idx = (m_rr + k) % NUM_SQ;
      if (((mi >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  function automatic bit model_exempt(input int w);
`ifdef NVME_SQ_URGENT_EN
    return (w == 0);
`else
    return (w < 0);
`endif
  endfunction

  task automatic model_grant(input int w);
    if (!model_exempt(w) && w != m_rr) m_burst = 0;
  endtask

  task automatic model_finish(input int w, input int st);
    if (model_exempt(w)) return;
    if (st != 2 && m_burst < BURST - 1) begin
      m_burst = m_burst + 1;
      m_rr = w;
    end else begin
      m_burst = 0;
      m_rr = (w + 1) % NUM_SQ;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sq_ready"}, int'(bus.sq_ready), 0);
    check({tag, "_cmd_valid"}, int'(bus.cmd_valid), 0);
    check({tag, "_cmd_data"}, int'(bus.cmd_data), 0);
    check({tag, "_cmd_qid"}, int'(bus.cmd_qid), 0);
    check({tag, "_done_valid"}, int'(bus.done_valid), 0);
    check({tag, "_done_qid"}, int'(bus.done_qid), 0);
    check({tag, "_done_status"}, int'(bus.done_status), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.sq_valid = '0;
    bus.cmd_ready = 1'b0;
    bus.cpl_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;
    m_rr = 0;
    m_burst = 0;
    cur_qid = -1;
  endtask

  // cpl_dly >= 0: completion in that WAIT_CPL cycle; -1: none (timeout); -2: reset during WAIT_CPL
  task automatic run_txn(input logic [NUM_SQ-1:0] mask, input int rdy_dly, input int cpl_dly,
                         input logic err, input bit stray, input int fixed_cmd);
    int w;
    int st;
    int n;
    grant_t g;
    done_t d;
    for (int i = 0; i < NUM_SQ; i++) begin
      cmds[i] = (fixed_cmd >= 0) ? CMD_W'(fixed_cmd) : CMD_W'($urandom);
    end
    w = model_pick(mask);
    g.qid = w;
    g.cmd = int'(cmds[w]);
    exp_grant.push_back(g);
    st = (cpl_dly >= 0) ? (err ? 1 : 0) : 2;
    if (cpl_dly != -2) begin
      d.qid = w;
      d.status = st;
      exp_done.push_back(d);
    end
    model_grant(w);

    @(negedge clk);
    bus.sq_valid = mask;
    for (int i = 0; i < NUM_SQ; i++) bus.sq_cmd[i*CMD_W +: CMD_W] = cmds[i];
    bus.cpl_valid = stray;
    bus.cpl_err = 1'b1;
    #1;
    if (bus.sq_ready == '0) abort("grant_wait");

    @(negedge clk);
    bus.sq_valid = '0;
    bus.cpl_valid = 1'b0;
    for (int r = 0; r < rdy_dly; r++) begin
      bus.cpl_valid = stray && (r % 2 == 0);
      @(negedge clk);
    end
    bus.cpl_valid = 1'b0;
    bus.cmd_ready = 1'b1;
    #1;
    check("cmd_valid_at_handshake", int'(bus.cmd_valid), 1);
    check("busy_in_issue", int'(bus.busy), 1);
    @(negedge clk);
    bus.cmd_ready = 1'b0;

    n = 0;
    forever begin
      bus.cpl_valid = (n == cpl_dly);
      bus.cpl_err = err;
      if (cpl_dly == -2 && n == 3) begin
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_rr = 0;
        m_burst = 0;
        cur_qid = -1;
        repeat (20) @(negedge clk);
        return;
      end
      #1;
      if (bus.done_valid) break;
      if (n > TMO + 4) abort("done_wait");
      @(negedge clk);
      n++;
    end
    bus.cpl_valid = 1'b0;
    check("done_latency", n, (cpl_dly >= 0) ? cpl_dly + 1 : TMO);
    model_finish(w, st);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant, a command or a completion
  grant_t mon_g;
  done_t  mon_d;
  int     mon_q;
  int     mon_sr;
  always @(negedge clk) begin
    #2;
    if (reset_n) begin
      if (bus.sq_ready != '0) begin
        check("sq_ready_onehot", int'($onehot(bus.sq_ready)), 1);
        mon_sr = int'(bus.sq_ready);
        mon_q = -1;
        for (int k = 0; k < NUM_SQ; k++) if (((mon_sr >> k) & 1) != 0) mon_q = k;
        grant_log.push_back(mon_q);
        if (exp_grant.size() == 0) begin
          check("spurious_grant", mon_q, -1);
        end else begin
          mon_g = exp_grant.pop_front();
          check("grant_qid", mon_q, mon_g.qid);
          cur_qid = mon_g.qid;
          cur_cmd = mon_g.cmd;
        end
      end
      if (bus.cmd_valid) begin
        check("cmd_data", int'(bus.cmd_data), cur_cmd);
        check("cmd_qid", int'(bus.cmd_qid), cur_qid);
        check("no_sq_ready_in_issue", int'(bus.sq_ready), 0);
      end
      if (bus.done_valid) begin
        if (exp_done.size() == 0) begin
          check("spurious_done", int'(bus.done_qid), -1);
        end else begin
          mon_d = exp_done.pop_front();
          check("done_qid", int'(bus.done_qid), mon_d.qid);
          check("done_status", int'(bus.done_status), mon_d.status);
        end
      end
    end
  end

  initial begin
    #500000;
    abort("global_time");
  end

  initial begin
    int order_exp [9];
    logic [NUM_SQ-1:0] mask;
    int r;
    int cd;
    bus.sq_valid = '0;
    bus.sq_cmd = '0;
    bus.cmd_ready = 1'b0;
    bus.cpl_valid = 1'b0;
    bus.cpl_err = 1'b0;
    apply_reset();

    // Q1 alone, command 0x0123, completion five cycles into WAIT_CPL
    run_txn(4'b0010, 0, 5, 1'b0, 1'b0, 16'h0123);

    // All queues valid from reset: bursts of two per queue
    apply_reset();
    grant_log.delete();
    for (int i = 0; i < 9; i++) run_txn(4'b1111, 0, 0, 1'b0, 1'b0, -1);
`ifdef NVME_SQ_URGENT_EN
    order_exp = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    order_exp = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
`endif
    check("grant_order_len", grant_log.size(), 9);
    for (int i = 0; i < 9 && i < grant_log.size(); i++) check("grant_order", grant_log[i], order_exp[i]);

    // Executor stalls ten cycles with stray completions that must be ignored
    run_txn(4'b0110, 10, 2, 1'b0, 1'b1, -1);
    // Lost completion times out, then the pointer moves past the timed-out queue
    run_txn(4'b1111, 1, -1, 1'b0, 1'b0, -1);
    run_txn(4'b1111, 0, 1, 1'b0, 1'b0, -1);
    // Completion with error on the timeout cycle wins over the timeout
    run_txn(4'b1111, 0, TMO - 1, 1'b1, 1'b0, -1);
    // Queue 2 bursting, queue 0 arrives, queue 2 comes back
    apply_reset();
    run_txn(4'b0100, 0, 0, 1'b0, 1'b0, -1);
    run_txn(4'b0101, 0, 0, 1'b0, 1'b0, -1);
    run_txn(4'b1100, 0, 0, 1'b0, 1'b0, -1);
    // Reset during WAIT_CPL: no completion report afterwards
    run_txn(4'b1000, 0, -2, 1'b0, 1'b0, -1);
    run_txn(4'b1111, 0, 3, 1'b1, 1'b0, -1);

    for (int t = 0; t < 80; t++) begin
      mask = ($urandom_range(0, 1) == 0) ? 4'b1111 : NUM_SQ'($urandom_range(1, 15));
      r = $urandom_range(0, 9);
      cd = (r < 7) ? $urandom_range(0, 6) : (r == 7) ? -1 : (r == 8) ? TMO - 1 : 0;
      run_txn(mask, $urandom_range(0, 3), cd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    repeat (5) @(negedge clk);
    check("grants_drained", exp_grant.size(), 0);
    check("dones_drained", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
